// File: rtl/fc_neuron_mac_pe.sv
// Fully-connected neuron PE: bias + sum(act*weight) over N_INPUTS FP32 pairs, one multiplier and one adder.
// Optional build macro FC_PE_RELU_EN clamps a negative result (including -0.0) to +0.0.

module fpMul #(
  parameter int DATA_WIDTH = 32,
  parameter int LAT        = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);
  logic        sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, hi, guard, sticky;
  logic [47:0] prod;
  logic [23:0] mant;
  logic [24:0] mant_r;
  logic [9:0]  exp_u;
  logic [7:0]  exp_f;
  logic [DATA_WIDTH-1:0] core_y;

  // Denormal operands are treated as zero; results round to nearest even.
  always_comb begin
    sign   = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == '0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != '0);
    prod   = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    hi     = prod[47];
    mant   = hi ? prod[47:24] : prod[46:23];
    guard  = hi ? prod[23] : prod[22];
    sticky = hi ? (|prod[22:0]) : (|prod[21:0]);
    mant_r = {1'b0, mant} + {24'b0, guard & (sticky | mant[0])};
    exp_u  = {2'b00, a[30:23]} + {2'b00, b[30:23]} + {9'b0, hi} + {9'b0, mant_r[24]};
    exp_f  = 8'(exp_u - 10'd127);
    core_y = {sign, exp_f, mant_r[24] ? mant_r[23:1] : mant_r[22:0]};
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      core_y = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      core_y = {sign, 8'hFF, 23'b0};
    end else if (a_zero || b_zero) begin
      core_y = {sign, 31'b0};
    end else if (exp_u >= 10'd382) begin
      core_y = {sign, 8'hFF, 23'b0};
    end else if (exp_u <= 10'd127) begin
      core_y = {sign, 31'b0};
    end
  end

  // LAT counts cycles until the consumer registers y; LAT-1 internal stages.
  if (LAT == 1) begin : g_comb
    assign y = core_y;
  end else begin : g_pipe
    logic [DATA_WIDTH-1:0] pipe_q [LAT-1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < LAT-1; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= core_y;
        for (int unsigned i = 1; i < LAT-1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign y = pipe_q[LAT-2];
  end
endmodule

module fp_add #(
  parameter int DATA_WIDTH = 32,
  parameter int LAT        = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);
  logic [DATA_WIDTH-1:0] x, v, core_y;
  logic [7:0]  ex, ey, d;
  logic        sub, rnd;
  logic [26:0] mx, my, my_sh, norm;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [9:0]  exp_n, exp_f;
  logic [24:0] mant_r;

  // x is the larger magnitude; 3 extra low bits carry guard/round/sticky.
  always_comb begin
    if (a[30:0] >= b[30:0]) begin
      x = a;
      v = b;
    end else begin
      x = b;
      v = a;
    end
    ex    = x[30:23];
    ey    = v[30:23];
    sub   = x[31] ^ v[31];
    d     = ex - ey;
    mx    = (ex == 8'h00) ? '0 : {1'b1, x[22:0], 3'b000};
    my    = (ey == 8'h00) ? '0 : {1'b1, v[22:0], 3'b000};
    my_sh = my >> d;
    my_sh[0] = my_sh[0] | (|(my & ~({27{1'b1}} << d)));
    sum   = sub ? ({1'b0, mx} - {1'b0, my_sh}) : ({1'b0, mx} + {1'b0, my_sh});
    lz    = '0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = {2'b00, ex} + 10'd1;
    end else begin
      norm  = sum[26:0] << lz;
      exp_n = {2'b00, ex} - {5'b0, lz};
    end
    rnd    = norm[2] & (norm[3] | norm[1] | norm[0]);
    mant_r = {1'b0, norm[26:3]} + {24'b0, rnd};
    exp_f  = exp_n + {9'b0, mant_r[24]};
    core_y = {x[31], exp_f[7:0], mant_r[24] ? mant_r[23:1] : mant_r[22:0]};
    if (ex == 8'hFF) begin
      core_y = ((x[22:0] != '0) || ((ey == 8'hFF) && sub)) ? 32'h7FC0_0000 : x;
    end else if (ex == 8'h00) begin
      core_y = {x[31] & v[31], 31'b0};
    end else if (sum == '0) begin
      core_y = '0;
    end else if (!sum[27] && ({3'b000, lz} >= ex)) begin
      core_y = {x[31], 31'b0};
    end else if (exp_f >= 10'd255) begin
      core_y = {x[31], 8'hFF, 23'b0};
    end
  end

  if (LAT == 1) begin : g_comb
    assign y = core_y;
  end else begin : g_pipe
    logic [DATA_WIDTH-1:0] pipe_q [LAT-1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < LAT-1; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= core_y;
        for (int unsigned i = 1; i < LAT-1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign y = pipe_q[LAT-2];
  end
endmodule

module fc_neuron_mac_pe #(
  parameter  int DATA_WIDTH = 32,
  parameter  int N_INPUTS   = 16,
  parameter  int MUL_LAT    = 1,
  parameter  int ADD_LAT    = 1,
  localparam int CNT_W      = $clog2(N_INPUTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] bias,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_act,
  input  logic [DATA_WIDTH-1:0] in_weight,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic [CNT_W-1:0]      in_count
);
  localparam int MAX_LAT = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
  localparam int WAIT_W  = $clog2(MAX_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_IN, S_MUL, S_ADD, S_OUT} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, act_q, act_d, weight_q, weight_d;
  logic [DATA_WIDTH-1:0] prod_q, prod_d, out_data_q, out_data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [DATA_WIDTH-1:0] mul_y, add_y, final_y;

  fpMul #(.DATA_WIDTH(DATA_WIDTH), .LAT(MUL_LAT)) u_mul (
    .clk(clk), .rst_n(rst_n), .a(act_q), .b(weight_q), .y(mul_y)
  );

  fp_add #(.DATA_WIDTH(DATA_WIDTH), .LAT(ADD_LAT)) u_add (
    .clk(clk), .rst_n(rst_n), .a(acc_q), .b(prod_q), .y(add_y)
  );

`ifdef FC_PE_RELU_EN
  assign final_y = add_y[DATA_WIDTH-1] ? '0 : add_y;
`else
  assign final_y = add_y;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      act_q      <= '0;
      weight_q   <= '0;
      prod_q     <= '0;
      out_data_q <= '0;
      cnt_q      <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      act_q      <= act_d;
      weight_q   <= weight_d;
      prod_q     <= prod_d;
      out_data_q <= out_data_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
    end
  end

  // The wait counter is reloaded on entry to MUL/ADD and the state exits at zero.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    act_d      = act_q;
    weight_d   = weight_q;
    prod_d     = prod_q;
    out_data_d = out_data_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = bias;
          cnt_d   = '0;
          state_d = S_WAIT_IN;
        end
      end
      S_WAIT_IN: begin
        if (in_valid) begin
          act_d    = in_act;
          weight_d = in_weight;
          wait_d   = WAIT_W'(MUL_LAT - 1);
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        if (wait_q == '0) begin
          prod_d  = mul_y;
          wait_d  = WAIT_W'(ADD_LAT - 1);
          state_d = S_ADD;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      S_ADD: begin
        if (wait_q == '0) begin
          acc_d = add_y;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(N_INPUTS - 1)) begin
            out_data_d = final_y;
            state_d    = S_OUT;
          end else begin
            state_d = S_WAIT_IN;
          end
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_WAIT_IN);
    out_valid = (state_q == S_OUT);
    busy      = (state_q != S_IDLE);
    out_data  = out_data_q;
    in_count  = cnt_q;
  end
endmodule

// File: tb/tb_fc_neuron_mac_pe.sv
// Directed bench for fc_neuron_mac_pe: N_INPUTS=4, MUL_LAT=2, ADD_LAT=3, both output builds.
module tb_fc_neuron_mac_pe;
  localparam int N     = 4;
  localparam int ML    = 2;
  localparam int AL    = 3;
  localparam int CNT_W = $clog2(N + 1);
  localparam int PAIR  = 1 + ML + AL;

  logic             clk = 1'b0;
  logic             rst_n, start, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0]      bias, in_act, in_weight, out_data;
  logic [CNT_W-1:0] in_count;
  logic [31:0]      act_v [N];
  logic [31:0]      wt_v  [N];
  int checks = 0;
  int errors = 0;

  fc_neuron_mac_pe #(.N_INPUTS(N), .MUL_LAT(ML), .ADD_LAT(AL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_weight(in_weight),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .in_count(in_count)
  );

  always #5 clk = ~clk;

  task automatic load_unit_pairs();
    for (int k = 0; k < N; k++) begin
      act_v[k] = 32'h3F80_0000;
      wt_v[k]  = 32'h4000_0000;
    end
  endtask

  // Runs one neuron from start until out_valid; gap=0 holds in_valid high throughout.
  task automatic drive_neuron(input logic [31:0] b, input int gap, input bit spam,
                              output logic [31:0] res, output int cyc,
                              output int cnt_bad, output bit tmo);
    int sent, idle, nexp;
    int hs_cyc [N];
    bit hs, gapc;
    sent = 0; idle = 0; cnt_bad = 0;
    bias = b; start = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    cyc = 1;
    start = spam;
    while (out_valid !== 1'b1 && cyc < 400) begin
      nexp = 0;
      for (int k = 0; k < sent; k++) if (cyc - hs_cyc[k] >= ML + AL) nexp++;
      if (in_count !== CNT_W'(nexp)) cnt_bad++;
      in_act    = (sent < N) ? act_v[sent] : $urandom;
      in_weight = (sent < N) ? wt_v[sent]  : $urandom;
      in_valid  = (sent < N) && (gap == 0 || (in_ready === 1'b1 && idle == 0));
      hs   = in_valid && (in_ready === 1'b1);
      gapc = !in_valid && (in_ready === 1'b1);
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        hs_cyc[sent] = cyc;
        sent++;
        idle = gap;
        in_act = $urandom;
        in_weight = $urandom;
      end else if (gapc && idle > 0) begin
        idle--;
      end
    end
    start = 1'b0; in_valid = 1'b0;
    tmo = (out_valid !== 1'b1);
    res = out_data;
  endtask

  task automatic ack_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; bias = '0; in_valid = 1'b0; in_act = '0; in_weight = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (in_count !== '0)    begin errors++; $display("FAIL rst_in_count got=%0d exp=0", in_count); end
    checks++; if (out_data !== '0)    begin errors++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] res; int cyc, bad; bit tmo;
    load_unit_pairs();
    drive_neuron(32'h0000_0000, 0, 1'b0, res, cyc, bad, tmo);
    checks++; if (tmo)                   begin errors++; $display("FAIL basic_timeout got=no out_valid exp=out_valid"); end
    checks++; if (cyc != 1 + N * PAIR)   begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", cyc, 1 + N * PAIR); end
    checks++; if (res !== 32'h4100_0000) begin errors++; $display("FAIL basic_data got=%h exp=41000000", res); end
    checks++; if (bad != 0)              begin errors++; $display("FAIL basic_in_count_steps got=%0d bad exp=0", bad); end
    checks++; if (in_count !== CNT_W'(N)) begin errors++; $display("FAIL basic_final_count got=%0d exp=%0d", in_count, N); end
    checks++; if (busy !== 1'b1)         begin errors++; $display("FAIL basic_busy_out got=%b exp=1", busy); end
    ack_out();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle_after_ack got=valid%b busy%b exp=0 0", out_valid, busy); end
    checks++; if (out_data !== 32'h4100_0000) begin errors++; $display("FAIL basic_data_hold got=%h exp=41000000", out_data); end
  endtask

  task automatic test_negative_bias();
    logic [31:0] res, exp_res; int cyc, bad; bit tmo;
`ifdef FC_PE_RELU_EN
    exp_res = 32'h0000_0000;
`else
    exp_res = 32'hC000_0000;
`endif
    load_unit_pairs();
    drive_neuron(32'hC120_0000, 0, 1'b0, res, cyc, bad, tmo);
    checks++; if (tmo || res !== exp_res) begin errors++; $display("FAIL negbias_data got=%h exp=%h", res, exp_res); end
    checks++; if (cyc != 1 + N * PAIR)    begin errors++; $display("FAIL negbias_latency got=%0d exp=%0d", cyc, 1 + N * PAIR); end
    ack_out();
  endtask

  task automatic test_gaps();
    logic [31:0] res; int cyc, bad; bit tmo;
    load_unit_pairs();
    drive_neuron(32'h0000_0000, 3, 1'b0, res, cyc, bad, tmo);
    checks++; if (tmo || res !== 32'h4100_0000) begin errors++; $display("FAIL gaps_data got=%h exp=41000000", res); end
    checks++; if (cyc != 1 + N * PAIR + 3 * (N - 1)) begin
      errors++; $display("FAIL gaps_latency got=%0d exp=%0d", cyc, 1 + N * PAIR + 3 * (N - 1)); end
    checks++; if (bad != 0) begin errors++; $display("FAIL gaps_in_count_steps got=%0d bad exp=0", bad); end
    ack_out();
  endtask

  task automatic test_rounding();
    logic [31:0] res; int cyc, bad; bit tmo;
    act_v[0] = 32'h3FC0_0000; wt_v[0] = 32'h4040_0000;  // 1.5*3.0
    act_v[1] = 32'h3F00_0000; wt_v[1] = 32'hC000_0000;  // 0.5*-2.0
    act_v[2] = 32'h3F80_0001; wt_v[2] = 32'h3F80_0001;  // sum lands on a tie
    act_v[3] = 32'h3F80_0001; wt_v[3] = 32'h4000_0000;  // sum lands on a tie
    drive_neuron(32'h3F80_0000, 0, 1'b0, res, cyc, bad, tmo);
    checks++; if (tmo || res !== 32'h40F0_0000) begin errors++; $display("FAIL round_data got=%h exp=40f00000", res); end
    ack_out();
  endtask

  task automatic test_out_stall();
    logic [31:0] res; int cyc, bad, unstable; bit tmo;
    load_unit_pairs();
    drive_neuron(32'h0000_0000, 0, 1'b0, res, cyc, bad, tmo);
    unstable = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_data !== 32'h4100_0000) unstable++;
    end
    checks++; if (tmo || unstable != 0) begin errors++; $display("FAIL stall_hold got=%0d unstable exp=0", unstable); end
    ack_out();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_release got=valid%b busy%b ready%b exp=0 0 0", out_valid, busy, in_ready); end
  endtask

  task automatic test_start_ignored();
    logic [31:0] res; int cyc, bad; bit tmo;
    load_unit_pairs();
    drive_neuron(32'h0000_0000, 0, 1'b1, res, cyc, bad, tmo);
    checks++; if (tmo || res !== 32'h4100_0000) begin errors++; $display("FAIL startign_data got=%h exp=41000000", res); end
    checks++; if (cyc != 1 + N * PAIR || bad != 0) begin
      errors++; $display("FAIL startign_timing got=%0d cycles %0d bad exp=%0d cycles 0 bad", cyc, bad, 1 + N * PAIR); end
    start = 1'b1; bias = 32'h4480_0000;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || in_count !== CNT_W'(N)) begin
      errors++; $display("FAIL startign_out got=valid%b cnt%0d exp=1 %0d", out_valid, in_count, N); end
    ack_out();
    start = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || out_data !== 32'h4100_0000) begin
      errors++; $display("FAIL startign_idle got=busy%b data%h exp=0 41000000", busy, out_data); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; int cyc, bad, w; bit tmo;
    load_unit_pairs();
    bias = '0; start = 1'b1;
    in_act = 32'h3F80_0000; in_weight = 32'h4000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (in_count !== CNT_W'(2) && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    checks++; if (w >= 100) begin errors++; $display("FAIL rstmid_reach_two got=%0d exp=2", in_count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctrl got=busy%b ready%b valid%b exp=0 0 0", busy, in_ready, out_valid); end
    checks++; if (in_count !== '0 || out_data !== '0) begin
      errors++; $display("FAIL rstmid_data got=cnt%0d data%h exp=0 0", in_count, out_data); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive_neuron(32'h0000_0000, 0, 1'b0, res, cyc, bad, tmo);
    checks++; if (tmo || res !== 32'h4100_0000 || cyc != 1 + N * PAIR) begin
      errors++; $display("FAIL rstmid_rerun got=%h in %0d exp=41000000 in %0d", res, cyc, 1 + N * PAIR); end
    ack_out();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative_bias();
    test_gaps();
    test_rounding();
    test_out_stall();
    test_start_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
